// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Holds in-flight branch predictions in FIFO order until the back end resolves
// them. Each resolve produces a one-cycle training strobe for the 2-bit counter
// table. A wrong prediction also produces a mispredict pulse and the corrected
// global history. A mispredict empties the queue and spends one FLUSH cycle
// with both handshakes closed.
//
// Optional feature: define BRQ_MISPRED_STATS_EN to add the saturating 16-bit
// mispred_count output.
//
// Parameters
//   DEPTH  entry count (power of two, >= 2)
//   IDX_W  counter-table index width
//   GHR_W  global-history snapshot width
//
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   pred_valid/ready       prediction handshake
//   pred_taken/index/ghr   prediction payload stored per entry
//   res_valid/ready        resolve handshake (always the oldest entry)
//   res_taken              actual direction of the oldest entry
//   upd_valid/index/taken  one-cycle counter-table training strobe
//   mispredict             one-cycle pulse on a wrong prediction
//   restore_ghr            corrected history {stored ghr[GHR_W-2:0], res_taken}
//   count                  number of valid entries
//   mispred_count          saturating mispredict count (BRQ_MISPRED_STATS_EN)
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  parameter int GHR_W = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [IDX_W-1:0]         pred_index,
  input  logic [GHR_W-1:0]         pred_ghr,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [GHR_W-1:0]         restore_ghr,
  output logic [$clog2(DEPTH):0]   count
`ifdef BRQ_MISPRED_STATS_EN
  ,
  output logic [15:0]              mispred_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // RUN   : normal push/pop operation
  // FLUSH : one cycle after a mispredict, both handshakes closed
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_next;

  logic             taken_mem [DEPTH];
  logic [IDX_W-1:0] index_mem [DEPTH];
  logic [GHR_W-1:0] ghr_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop, mispred_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a
  // slot for a push.
  assign pred_ready  = (state == RUN) && (count < FULL_CNT);
  assign res_ready   = (state == RUN) && (count != '0);
  assign push        = pred_valid && pred_ready;
  assign pop         = res_valid && res_ready;
  // Gated by pop so that an unwritten entry cannot leak X into the state.
  assign mispred_pop = pop && (taken_mem[rd_ptr] != res_taken);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispred_pop) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A mispredict discards everything, including a push in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispred_pop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only slots below count are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      taken_mem[wr_ptr] <= pred_taken;
      index_mem[wr_ptr] <= pred_index;
      ghr_mem[wr_ptr]   <= pred_ghr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      restore_ghr <= '0;
    end else begin
      upd_valid  <= pop;
      mispredict <= mispred_pop;
      if (pop) begin
        upd_index   <= index_mem[rd_ptr];
        upd_taken   <= res_taken;
        restore_ghr <= {ghr_mem[rd_ptr][GHR_W-2:0], res_taken};
      end
    end
  end

`ifdef BRQ_MISPRED_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      mispred_count <= '0;
    else if (mispredict && (mispred_count != 16'hFFFF))
      mispred_count <= mispred_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int IDX_W = 10;
  localparam int GHR_W = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic             pred_valid, pred_taken, pred_ready;
  logic [IDX_W-1:0] pred_index;
  logic [GHR_W-1:0] pred_ghr;
  logic             res_valid, res_taken, res_ready;
  logic             upd_valid, upd_taken, mispredict;
  logic [IDX_W-1:0] upd_index;
  logic [GHR_W-1:0] restore_ghr;
  logic [$clog2(DEPTH):0] count;
`ifdef BRQ_MISPRED_STATS_EN
  logic [15:0]      mispred_count;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
    .pred_ghr(pred_ghr), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .restore_ghr(restore_ghr), .count(count)
`ifdef BRQ_MISPRED_STATS_EN
    , .mispred_count(mispred_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             taken;
    logic [IDX_W-1:0] index;
    logic [GHR_W-1:0] ghr;
  } ent_t;

  typedef struct {
    logic [IDX_W-1:0] index;
    logic             taken;
    logic             mis;
    logic [GHR_W-1:0] ghr;
  } upd_t;

  // Reference model: a plain queue of pending branches plus a flush flag.
  ent_t q[$];
  upd_t exp_q[$];
  upd_t last_upd, mon_r;
  bit   flush;
  int   n_mis;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every negedge, the strobe either matches the oldest
  // expected update or the outputs are idle and holding.
  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q.size() > 0) begin
        mon_r = exp_q.pop_front();
        check("upd_valid",   int'(upd_valid),   1);
        check("upd_index",   int'(upd_index),   int'(mon_r.index));
        check("upd_taken",   int'(upd_taken),   int'(mon_r.taken));
        check("mispredict",  int'(mispredict),  int'(mon_r.mis));
        check("restore_ghr", int'(restore_ghr), int'(mon_r.ghr));
        last_upd = mon_r;
      end else begin
        check("upd_valid_idle",   int'(upd_valid),   0);
        check("mispredict_idle",  int'(mispredict),  0);
        check("upd_index_hold",   int'(upd_index),   int'(last_upd.index));
        check("upd_taken_hold",   int'(upd_taken),   int'(last_upd.taken));
        check("restore_ghr_hold", int'(restore_ghr), int'(last_upd.ghr));
      end
    end
  end

  // One clock of stimulus; readiness and count are checked against the model
  // at the negedge, then the model commits the handshakes at the posedge.
  task automatic step(input logic pv, input logic pt, input logic [IDX_W-1:0] pi,
                      input logic [GHR_W-1:0] pg, input logic rv, input logic rt);
    bit m_pr, m_rr, do_push, do_pop, mis;
    ent_t e;
    upd_t u;
    pred_valid = pv; pred_taken = pt; pred_index = pi; pred_ghr = pg;
    res_valid  = rv; res_taken  = rt;
    @(negedge clock);
    m_pr = !flush && (q.size() < DEPTH);
    m_rr = !flush && (q.size() > 0);
    check("pred_ready", int'(pred_ready), int'(m_pr));
    check("res_ready",  int'(res_ready),  int'(m_rr));
    check("count",      int'(count),      q.size());
    do_push = pv && m_pr;
    do_pop  = rv && m_rr;
    @(posedge clock);
    mis = 1'b0;
    if (flush) flush = 1'b0;
    if (do_pop) begin
      e = q.pop_front();
      mis = (e.taken != rt);
      u.index = e.index; u.taken = rt; u.mis = mis;
      u.ghr = {e.ghr[GHR_W-2:0], rt};
      exp_q.push_back(u);
    end
    if (do_push) begin
      e.taken = pt; e.index = pi; e.ghr = pg;
      q.push_back(e);
    end
    if (mis) begin
      q.delete();
      flush = 1'b1;
      n_mis++;
    end
    #1;
  endtask

  function automatic logic oldest_taken();
    return (q.size() > 0) ? q[0].taken : 1'b0;
  endfunction

  task automatic push_one(input logic pt, input int idx, input int ghr);
    step(1'b1, pt, IDX_W'(idx), GHR_W'(ghr), 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom), IDX_W'($urandom), GHR_W'($urandom), 1'b0, 1'($urandom));
  endtask

  // Asynchronous reset between edges; discards model state and pending strobes.
  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    q.delete(); exp_q.delete(); flush = 1'b0;
    last_upd = '{default: '0};
    #1;
    check({tag, "_count"},      int'(count),       0);
    check({tag, "_upd_valid"},  int'(upd_valid),   0);
    check({tag, "_mispredict"}, int'(mispredict),  0);
    check({tag, "_pred_ready"}, int'(pred_ready),  1);
    check({tag, "_res_ready"},  int'(res_ready),   0);
    check({tag, "_upd_index"},  int'(upd_index),   0);
    check({tag, "_restore"},    int'(restore_ghr), 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pv, rv, rt;
    reset = 1'b1;
    pred_valid = 0; pred_taken = 0; pred_index = '0; pred_ghr = '0;
    res_valid = 0; res_taken = 0;
    flush = 0; n_mis = 0;
    last_upd = '{default: '0};
    #1;
    check("rst_pred_ready", int'(pred_ready), 1);
    check("rst_res_ready",  int'(res_ready),  0);
    check("rst_count",      int'(count),      0);
    check("rst_upd_valid",  int'(upd_valid),  0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single correct resolve.
    push_one(1'b1, 5, 12'h001);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    check("r40_upd_index", int'(upd_index), 5);
    check("r40_upd_taken", int'(upd_taken), 1);
    idle();

    // Fill to DEPTH, then pop and push together: push refused.
    for (int i = 0; i < DEPTH; i++) push_one(1'($urandom), 16 + i, 12'($urandom));
    step(1'b1, 1'b0, IDX_W'(99), '0, 1'b1, oldest_taken());
    idle();
    check("r41_count_after", int'(count), DEPTH - 1);
    while (q.size() > 0) step(1'b0, 1'b0, '0, '0, 1'b1, oldest_taken());
    idle();

    // Mispredict on the oldest of three, with a push in the same cycle.
    push_one(1'b0, 7, 12'h0AA);
    push_one(1'b1, 8, 12'h0BB);
    push_one(1'b1, 9, 12'h0CC);
    step(1'b1, 1'b1, IDX_W'(10), 12'h0DD, 1'b1, 1'b1);
    check("r42_restore_ghr", int'(restore_ghr), 12'h155);
    check("r42_mispredict",  int'(mispredict),  1);
    idle();  // FLUSH cycle: readies 0, count 0 checked in step
    idle();  // back in RUN

    // Empty queue: simultaneous push and resolve, no pop.
    step(1'b1, 1'b1, IDX_W'(3), 12'h123, 1'b1, 1'b1);
    idle();
    check("r43_count", int'(count), 1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);

    // Reset with 4 entries queued and a pop in flight.
    for (int i = 0; i < 4; i++) push_one(1'b1, 40 + i, 12'($urandom));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    async_reset_check("r44");
    idle();

    // Reset during FLUSH.
    push_one(1'b1, 11, 12'h00F);
    push_one(1'b0, 12, 12'h0F0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    async_reset_check("rflush");
    idle();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      pv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 50);
      rt = ($urandom_range(0, 99) < 85) ? oldest_taken() : 1'($urandom);
      step(pv, 1'($urandom), IDX_W'($urandom), GHR_W'($urandom), rv, rt);
    end
    idle();
    idle();

`ifdef BRQ_MISPRED_STATS_EN
    check("mispred_count", int'(mispred_count), (n_mis > 65535) ? 65535 : n_mis);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 8, sets the queue entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter IDX_W, default 10, sets the width of the counter-table index.
REQ-003 Parameter GHR_W, default 12, sets the width of the global-history snapshot.
REQ-004 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pred_valid  input  1  the predictor has issued a prediction.
REQ-007 pred_taken  input  1  predicted direction (1 = taken).
REQ-008 pred_index  input  IDX_W  counter-table index used for the prediction.
REQ-009 pred_ghr  input  GHR_W  global history before the speculative update.
REQ-010 pred_ready  output  1  the queue can accept a prediction.
REQ-011 res_valid  input  1  the oldest outstanding branch has resolved.
REQ-012 res_taken  input  1  actual direction.
REQ-013 res_ready  output  1  the queue holds an entry that can be resolved.
REQ-014 upd_valid  output  1  one-cycle training strobe to the 2-bit counter table.
REQ-015 upd_index  output  IDX_W  counter entry to train.
REQ-016 upd_taken  output  1  training direction; it drives the counter's BranchTaken input.
REQ-017 mispredict  output  1  one-cycle pulse; the stored prediction did not equal res_taken.
REQ-018 restore_ghr  output  GHR_W  corrected history, equal to {stored ghr[GHR_W-2:0], res_taken}.
REQ-019 count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 A push SHALL occur when pred_valid and pred_ready are both 1; the entry stores {pred_taken, pred_index, pred_ghr} at the write pointer.
REQ-021 A pop SHALL occur when res_valid and res_ready are both 1; entries SHALL be popped in strict FIFO order.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL be incremented on a push, decremented on a pop, and unchanged when both occur together.
REQ-023 pred_ready SHALL be 1 only when state is RUN and count < DEPTH; when full it SHALL be 0 even if a pop occurs in the same cycle.
REQ-024 res_ready SHALL be 1 only when state is RUN and count > 0; on an empty queue, a push and res_valid in the same cycle SHALL result in no pop.
REQ-025 upd_valid, upd_index, upd_taken, mispredict and restore_ghr SHALL be registered and valid exactly one cycle after the pop; upd_taken SHALL equal res_taken.
REQ-026 Outside that cycle, upd_valid and mispredict SHALL be 0, and upd_index, upd_taken and restore_ghr SHALL hold their last values.
REQ-027 The FSM SHALL have two states, RUN and FLUSH.
REQ-028 The FSM SHALL go from RUN to FLUSH on a pop whose stored prediction does not equal res_taken, and otherwise stay in RUN.
REQ-029 The FSM SHALL go from FLUSH back to RUN unconditionally after one cycle.
REQ-030 On a mispredicting pop, all remaining entries and any push accepted in the same cycle SHALL be discarded, and count SHALL be 0 on entry to FLUSH.
REQ-031 In FLUSH, pred_ready and res_ready SHALL be 0, and the mispredict pulse coincides with the FLUSH cycle.
REQ-032 Inputs SHALL be ignored when their handshake does not complete; X on the data inputs SHALL not propagate when the corresponding valid is 0.

Reset
REQ-033 While reset is 1, the state SHALL be RUN and the pointers and count SHALL be 0.
REQ-034 While reset is 1, pred_ready SHALL be 1 and res_ready SHALL be 0.
REQ-035 While reset is 1, upd_valid, upd_index, upd_taken, mispredict and restore_ghr SHALL all be 0.
REQ-036 Reset asserted mid-operation, including during FLUSH, SHALL discard all entries immediately and asynchronously; no update strobe SHALL issue for discarded entries.

Configuration
REQ-037 With BRQ_MISPRED_STATS_EN defined, an extra output mispred_count (16 bits) SHALL count mispredict pulses and saturate at 16'hFFFF.
REQ-038 mispred_count SHALL be reset to 0.
REQ-039 Without BRQ_MISPRED_STATS_EN, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then push taken (idx 5, ghr 0x001), then pop res_taken=1 -> next cycle upd_valid=1, upd_index=5, upd_taken=1, mispredict=0, count=0.
REQ-041 Push 8 entries with DEPTH=8 -> count=8, pred_ready=0; then a pop and pred_valid in the same cycle -> push refused, count=7.
REQ-042 Push 3 entries, then pop the first with a wrong direction (pred 0, res 1, ghr 0x0AA) -> mispredict=1, restore_ghr=0x155, count=0, one FLUSH cycle with both ready signals 0, then RUN.
REQ-043 On an empty queue, res_valid=1 and pred_valid=1 in one cycle -> no update strobe, count=1.
REQ-044 Assert reset with 4 entries queued and pops in flight -> count=0 immediately, no upd_valid; after release, pred_ready=1.
REQ-045 With the macro defined, force 70000 mispredicts -> mispred_count=16'hFFFF.
